// File: rtl/register_operand_fetch.sv
// Operand-fetch stage ahead of the R-type ALU: decode, 32x32 register file, RAW scoreboard.
// Define REGISTER_BYPASS_EN to forward same-cycle writeback data into the issued operands.
module register_operand_fetch #(
    parameter logic [6:0]  R_TYPE_OPCODE        = 7'b0110011,
    parameter logic [31:0] REGISTER_RESET_VALUE = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instruction_valid,
    output logic        instruction_ready,
    input  logic [31:0] instruction,
    input  logic        writeback_enable,
    input  logic [4:0]  writeback_address,
    input  logic [31:0] writeback_value,
    input  logic        flush,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [2:0]  subfunction_3,
    output logic [6:0]  subfunction_7,
    output logic [4:0]  destination_register,
    output logic [31:0] input_register1_value,
    output logic [31:0] input_register2_value,
    output logic        decode_error
);

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        decode_ok;
    logic [31:0] regs [0:31];
    logic [31:0] scoreboard;
    logic [31:0] scoreboard_next;
    logic        wb_hit;
    logic        wb_rs1;
    logic        wb_rs2;
    logic        hazard_rs1;
    logic        hazard_rs2;
    logic        hazard;
    logic        accept;
    logic        complete;
    logic [31:0] operand1;
    logic [31:0] operand2;

    assign opcode    = instruction[6:0];
    assign rd        = instruction[11:7];
    assign rs1       = instruction[19:15];
    assign rs2       = instruction[24:20];
    assign decode_ok = (opcode == R_TYPE_OPCODE);

    assign wb_hit = writeback_enable && (writeback_address != 5'd0);
    assign wb_rs1 = wb_hit && (writeback_address == rs1);
    assign wb_rs2 = wb_hit && (writeback_address == rs2);

    // Scoreboard bit 0 is never set, so x0 sources can never stall.
`ifdef REGISTER_BYPASS_EN
    assign hazard_rs1 = scoreboard[rs1] && !wb_rs1;
    assign hazard_rs2 = scoreboard[rs2] && !wb_rs2;
`else
    assign hazard_rs1 = scoreboard[rs1] || wb_rs1;
    assign hazard_rs2 = scoreboard[rs2] || wb_rs2;
`endif
    assign hazard = hazard_rs1 || hazard_rs2;

    assign instruction_ready = (!issue_valid || issue_ready) && !hazard && !flush;
    assign accept            = instruction_valid && instruction_ready;
    assign complete          = issue_valid && issue_ready;

    always_comb begin
        operand1 = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
        operand2 = (rs2 == 5'd0) ? 32'h0 : regs[rs2];
`ifdef REGISTER_BYPASS_EN
        if (wb_rs1) operand1 = writeback_value;
        if (wb_rs2) operand2 = writeback_value;
`endif
    end

    // Set is applied after clear: the accepted instruction is younger than the writeback.
    always_comb begin
        scoreboard_next = scoreboard;
        if (wb_hit) scoreboard_next[writeback_address] = 1'b0;
        if (accept && decode_ok && (rd != 5'd0)) scoreboard_next[rd] = 1'b1;
        if (flush) scoreboard_next = '0;
        scoreboard_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scoreboard <= '0;
        end else begin
            scoreboard <= scoreboard_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= (i == 0) ? 32'h0 : REGISTER_RESET_VALUE;
            end
        end else if (wb_hit) begin
            regs[writeback_address] <= writeback_value;
        end
    end

    // Issue register: loads on accept, holds under backpressure, drops on flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issue_valid           <= 1'b0;
            subfunction_3         <= '0;
            subfunction_7         <= '0;
            destination_register  <= '0;
            input_register1_value <= '0;
            input_register2_value <= '0;
            decode_error          <= 1'b0;
        end else if (flush) begin
            issue_valid <= 1'b0;
        end else if (accept) begin
            issue_valid           <= 1'b1;
            subfunction_3         <= instruction[14:12];
            subfunction_7         <= instruction[31:25];
            destination_register  <= decode_ok ? rd : 5'd0;
            input_register1_value <= operand1;
            input_register2_value <= operand2;
            decode_error          <= !decode_ok;
        end else if (complete) begin
            issue_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_register_operand_fetch.sv
// Directed plus randomized bench for register_operand_fetch against a behavioural model.
module tb_register_operand_fetch;

`ifdef REGISTER_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        instruction_valid = 1'b0;
    logic        instruction_ready;
    logic [31:0] instruction = 32'h0;
    logic        writeback_enable = 1'b0;
    logic [4:0]  writeback_address = 5'd0;
    logic [31:0] writeback_value = 32'h0;
    logic        flush = 1'b0;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic [2:0]  subfunction_3;
    logic [6:0]  subfunction_7;
    logic [4:0]  destination_register;
    logic [31:0] input_register1_value;
    logic [31:0] input_register2_value;
    logic        decode_error;

    register_operand_fetch dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .instruction_valid     (instruction_valid),
        .instruction_ready     (instruction_ready),
        .instruction           (instruction),
        .writeback_enable      (writeback_enable),
        .writeback_address     (writeback_address),
        .writeback_value       (writeback_value),
        .flush                 (flush),
        .issue_valid           (issue_valid),
        .issue_ready           (issue_ready),
        .subfunction_3         (subfunction_3),
        .subfunction_7         (subfunction_7),
        .destination_register  (destination_register),
        .input_register1_value (input_register1_value),
        .input_register2_value (input_register2_value),
        .decode_error          (decode_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: architectural values, set of registers with an outstanding producer,
    // and the instruction currently held for the ALU.
    logic [31:0] m_regs [32];
    bit   [31:0] m_pending;
    bit          m_iv;
    logic [2:0]  m_f3;
    logic [6:0]  m_f7;
    logic [4:0]  m_rd;
    logic [31:0] m_op1;
    logic [31:0] m_op2;
    bit          m_err;
    bit          m_accepted;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] s2,
                                          input logic [4:0] s1, input logic [2:0] f3,
                                          input logic [4:0] d);
        return {f7, s2, s1, f3, d, 7'b0110011};
    endfunction

    function automatic bit src_stalls(input logic [4:0] r);
        bit written_now;
        written_now = writeback_enable && (writeback_address == r);
        if (r == 5'd0) return 1'b0;
        if (BYPASS) return m_pending[r] && !written_now;
        return m_pending[r] || written_now;
    endfunction

    function automatic logic [31:0] src_value(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
        if (BYPASS && writeback_enable && (writeback_address == r)) return writeback_value;
        return m_regs[r];
    endfunction

    function automatic bit model_ready();
        return (!m_iv || issue_ready) && !flush
               && !src_stalls(instruction[19:15]) && !src_stalls(instruction[24:20]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_pending = '0;
        m_iv = 1'b0;
        m_accepted = 1'b0;
    endtask

    task automatic model_edge(input bit rdy);
        bit acc;
        bit is_r;
        acc  = instruction_valid && rdy;
        is_r = (instruction[6:0] == 7'b0110011);
        m_accepted = acc;
        if (flush) begin
            m_iv = 1'b0;
            m_pending = '0;
        end else begin
            if (acc) begin
                m_iv  = 1'b1;
                m_f3  = instruction[14:12];
                m_f7  = instruction[31:25];
                m_rd  = is_r ? instruction[11:7] : 5'd0;
                m_err = !is_r;
                m_op1 = src_value(instruction[19:15]);
                m_op2 = src_value(instruction[24:20]);
            end else if (m_iv && issue_ready) begin
                m_iv = 1'b0;
            end
            if (writeback_enable && writeback_address != 5'd0) m_pending[writeback_address] = 1'b0;
            if (acc && is_r && instruction[11:7] != 5'd0) m_pending[instruction[11:7]] = 1'b1;
        end
        if (writeback_enable && writeback_address != 5'd0) m_regs[writeback_address] = writeback_value;
    endtask

    task automatic check_outputs();
        check("issue_valid", issue_valid, m_iv);
        if (m_iv) begin
            check("subfunction_3", subfunction_3, m_f3);
            check("subfunction_7", subfunction_7, m_f7);
            check("destination_register", destination_register, m_rd);
            check("input_register1_value", input_register1_value, m_op1);
            check("input_register2_value", input_register2_value, m_op2);
            check("decode_error", decode_error, m_err);
        end
    endtask

    // One clock: ready is checked mid-cycle, state is checked just after the edge.
    task automatic step();
        bit rdy;
        @(negedge clk);
        rdy = model_ready();
        check("instruction_ready", instruction_ready, rdy);
        @(posedge clk);
        model_edge(rdy);
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input bit ir,
                         input bit wbe, input logic [4:0] wa, input logic [31:0] wv,
                         input bit fl);
        instruction_valid = v;
        instruction       = ins;
        issue_ready       = ir;
        writeback_enable  = wbe;
        writeback_address = wa;
        writeback_value   = wv;
        flush             = fl;
    endtask

    task automatic apply_reset();
        writeback_enable = 1'b0;
        flush = 1'b0;
        reset_n = 1'b0;
        #2;
        check("rst_issue_valid", issue_valid, 0);
        check("rst_subfunction_3", subfunction_3, 0);
        check("rst_subfunction_7", subfunction_7, 0);
        check("rst_destination_register", destination_register, 0);
        check("rst_input_register1_value", input_register1_value, 0);
        check("rst_input_register2_value", input_register2_value, 0);
        check("rst_decode_error", decode_error, 0);
        model_reset();
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        model_reset();
        @(posedge clk);
        #1;
        apply_reset();

        // Writeback x5, then ADD x7,x5,x0.
        drive(0, 32'h0, 1, 1, 5'd5, 32'h0000_1234, 0);
        step();
        drive(1, rtype(7'h00, 5'd0, 5'd5, 3'd0, 5'd7), 0, 0, 5'd0, 32'h0, 0);
        step();
        check("add_op1", input_register1_value, 32'h0000_1234);
        check("add_op2", input_register2_value, 32'h0);
        check("add_rd", destination_register, 32'd7);
        drive(0, 32'h0, 1, 0, 5'd0, 32'h0, 0);
        step();

        // RAW stall: ADD x3,x1,x2 then SUB x4,x3,x1 waits for x3.
        drive(1, rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 1, 0, 5'd0, 32'h0, 0);
        step();
        drive(1, rtype(7'h20, 5'd1, 5'd3, 3'd0, 5'd4), 1, 0, 5'd0, 32'h0, 0);
        step();
        step();
        writeback_enable = 1'b1;
        writeback_address = 5'd3;
        writeback_value = 32'hDEAD_BEEF;
        n = 0;
        while (1) begin
            step();
            writeback_enable = 1'b0;
            if (m_accepted) break;
            n++;
            if (n > 4) begin
                check("raw_wait_bound", n, 0);
                break;
            end
        end
        check("raw_accept_delay", n, BYPASS ? 0 : 1);
        check("raw_op1", input_register1_value, 32'hDEAD_BEEF);
        check("raw_f7", subfunction_7, 32'h20);

        // Backpressure then back-to-back accept.
        drive(1, rtype(7'h00, 5'd12, 5'd11, 3'd0, 5'd10), 1, 0, 5'd0, 32'h0, 0);
        step();
        drive(1, rtype(7'h00, 5'd0, 5'd0, 3'd2, 5'd13), 0, 0, 5'd0, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_rd_held", destination_register, 32'd10);
        end
        issue_ready = 1'b1;
        step();
        check("b2b_valid", issue_valid, 1);
        check("b2b_rd", destination_register, 32'd13);
        check("b2b_f3", subfunction_3, 32'd2);

        // Decode error.
        drive(1, 32'h0000_0013, 1, 0, 5'd0, 32'h0, 0);
        step();
        check("derr_flag", decode_error, 1);
        check("derr_rd", destination_register, 0);
        drive(0, 32'h0, 1, 0, 5'd0, 32'h0, 0);
        step();

        // Bypass: producer of x9, then ADD x1,x9,x9 alongside writeback of x9.
        drive(1, rtype(7'h00, 5'd0, 5'd0, 3'd0, 5'd9), 1, 0, 5'd0, 32'h0, 0);
        step();
        drive(1, rtype(7'h00, 5'd9, 5'd9, 3'd0, 5'd1), 1, 1, 5'd9, 32'hA5A5_A5A5, 0);
        n = 0;
        while (1) begin
            step();
            writeback_enable = 1'b0;
            if (m_accepted) break;
            n++;
            if (n > 4) begin
                check("byp_wait_bound", n, 0);
                break;
            end
        end
        check("byp_accept_delay", n, BYPASS ? 0 : 1);
        check("byp_op1", input_register1_value, 32'hA5A5_A5A5);
        check("byp_op2", input_register2_value, 32'hA5A5_A5A5);

        // Flush with three outstanding producers.
        drive(0, 32'h0, 1, 0, 5'd0, 32'h0, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, rtype(7'h00, 5'd0, 5'd0, 3'd0, 5'(20 + i)), 1, 0, 5'd0, 32'h0, 0);
            step();
        end
        check("pre_flush_valid", issue_valid, 1);
        drive(1, rtype(7'h00, 5'd21, 5'd20, 3'd0, 5'd23), 0, 1, 5'd6, 32'h0000_0066, 1);
        step();
        check("flush_valid", issue_valid, 0);
        drive(1, rtype(7'h00, 5'd22, 5'd20, 3'd0, 5'd23), 1, 0, 5'd0, 32'h0, 0);
        step();
        check("post_flush_accept", issue_valid, 1);

        // Reset in the middle of a stall on x23.
        drive(1, rtype(7'h00, 5'd0, 5'd23, 3'd0, 5'd24), 1, 0, 5'd0, 32'h0, 0);
        step();
        check("pre_reset_stalled", instruction_ready, 0);
        apply_reset();
        step();
        check("post_reset_op1", input_register1_value, 0);
        for (int i = 1; i < 32; i += 2) begin
            drive(1, rtype(7'h00, 5'((i + 1) % 32), 5'(i), 3'd0, 5'd0), 1, 0, 5'd0, 32'h0, 0);
            step();
        end

        // Randomized traffic on a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            ins = rtype(7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        3'($urandom), 5'($urandom_range(0, 7)));
            if ($urandom_range(0, 7) == 0) ins[6:0] = 7'($urandom);
            drive($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 31) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
